simmem_wdata_sequencer: RTL and testbench

// - Requester-side transmitter for the write channels snooped by the delay calculator.
// - Buffers write address requests and forwards them on waddr_o.
// - Gates the upstream write data stream so exactly burst_len beats go out per address, in address order.
// - Generates wdata_last_o on the final beat of each burst.
// - Sits between the traffic generator and the simulated-memory interface; the simulated memory sees correctly framed W bursts.

---
 rtl/simmem_pkg.sv | 19 +
 rtl/simmem_wdata_sequencer.sv | 98 +++++++++
 tb/tb_simmem_wdata_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simmem_pkg.sv
// rtl/simmem_pkg.sv - shared simulated-memory types and widths for the write-channel blocks.
package simmem_pkg;

  localparam int unsigned IdWidth       = 4;
  localparam int unsigned AddrWidth     = 16;
  localparam int unsigned DataWidth     = 32;
  localparam int unsigned AxLenWidth    = 4;
  localparam int unsigned MaxWBurstLen  = 8;
  localparam int unsigned WDataSeqDepth = 8;

  typedef struct packed {
    logic [IdWidth-1:0]    id;
    logic [AddrWidth-1:0]  addr;
    logic [AxLenWidth-1:0] burst_len;
  } waddr_t;

  typedef logic [DataWidth-1:0] wdata_t;

endpackage

// File: rtl/simmem_wdata_sequencer.sv
// rtl/simmem_wdata_sequencer.sv - queues write addresses and frames the W stream into bursts.
// SIMMEM_WDATA_EARLY_EN lets a burst's data start before its address has been issued.
module simmem_wdata_sequencer
  import simmem_pkg::*;
#(
  parameter int unsigned Depth = WDataSeqDepth
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  waddr_t                 waddr_i,
  input  logic                   waddr_valid_i,
  output logic                   waddr_ready_o,
  output waddr_t                 waddr_o,
  output logic                   waddr_valid_o,
  input  logic                   waddr_ready_i,
  input  wdata_t                 wdata_i,
  input  logic                   wdata_valid_i,
  output logic                   wdata_ready_o,
  output wdata_t                 wdata_o,
  output logic                   wdata_last_o,
  output logic                   wdata_valid_o,
  input  logic                   wdata_ready_i,
  output logic [$clog2(Depth):0] pending_o
);

  localparam int unsigned IdxW = $clog2(Depth);
  localparam int unsigned PtrW = IdxW + 1;

  typedef logic [PtrW-1:0] ptr_t;

  waddr_t                mem [Depth];
  ptr_t                  wr_ptr, addr_ptr, data_ptr;
  ptr_t                  addr_occ, data_occ, limit;
  logic [AxLenWidth-1:0] beat_cnt, cur_len;
  logic                  push, addr_hs, beat_hs, last_hs, zero_skip;
  logic                  entry_avail, burst_active;

  // Occupancy is set by whichever reader pointer lags furthest behind the writer.
  assign addr_occ      = wr_ptr - addr_ptr;
  assign data_occ      = wr_ptr - data_ptr;
  assign pending_o     = (addr_occ > data_occ) ? addr_occ : data_occ;
  assign waddr_ready_o = (pending_o != PtrW'(Depth));
  assign push          = waddr_valid_i && waddr_ready_o;

  assign waddr_valid_o = (addr_ptr != wr_ptr);
  assign waddr_o       = mem[addr_ptr[IdxW-1:0]];
  assign addr_hs       = waddr_valid_o && waddr_ready_i;

`ifdef SIMMEM_WDATA_EARLY_EN
  assign limit = wr_ptr;
`else
  assign limit = addr_ptr;
`endif

  assign cur_len      = mem[data_ptr[IdxW-1:0]].burst_len;
  assign entry_avail  = (data_ptr != limit);
  assign burst_active = entry_avail && (cur_len != '0);
  assign zero_skip    = entry_avail && (cur_len == '0);

  assign wdata_o       = wdata_i;
  assign wdata_valid_o = wdata_valid_i && burst_active;
  assign wdata_ready_o = wdata_ready_i && burst_active;
  assign wdata_last_o  = burst_active && (beat_cnt == cur_len - AxLenWidth'(1));
  assign beat_hs       = wdata_valid_o && wdata_ready_i;
  assign last_hs       = beat_hs && wdata_last_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      addr_ptr <= '0;
      data_ptr <= '0;
      beat_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PtrW'(1);
      end
      if (addr_hs) begin
        addr_ptr <= addr_ptr + PtrW'(1);
      end
      if (last_hs || zero_skip) begin
        data_ptr <= data_ptr + PtrW'(1);
      end
      if (last_hs) begin
        beat_cnt <= '0;
      end else if (beat_hs) begin
        beat_cnt <= beat_cnt + AxLenWidth'(1);
      end
    end
  end

  // Address payload only; write data is never stored here.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr[IdxW-1:0]] <= waddr_i;
    end
  end

endmodule

// File: tb/tb_simmem_wdata_sequencer.sv
// tb/tb_simmem_wdata_sequencer.sv - scoreboard bench for the write-data sequencer.
module tb_simmem_wdata_sequencer;
  import simmem_pkg::*;

  localparam int Depth = WDataSeqDepth;

  logic   clk = 1'b0;
  logic   rst_ni = 1'b0;
  waddr_t waddr_i = '0;
  logic   waddr_valid_i = 1'b0;
  logic   waddr_ready_o;
  waddr_t waddr_o;
  logic   waddr_valid_o;
  logic   waddr_ready_i = 1'b0;
  wdata_t wdata_i = '0;
  logic   wdata_valid_i = 1'b0;
  logic   wdata_ready_o;
  wdata_t wdata_o;
  logic   wdata_last_o;
  logic   wdata_valid_o;
  logic   wdata_ready_i;
  logic [$clog2(Depth):0] pending_o;

  simmem_wdata_sequencer #(.Depth(Depth)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .waddr_i      (waddr_i),
    .waddr_valid_i(waddr_valid_i),
    .waddr_ready_o(waddr_ready_o),
    .waddr_o      (waddr_o),
    .waddr_valid_o(waddr_valid_o),
    .waddr_ready_i(waddr_ready_i),
    .wdata_i      (wdata_i),
    .wdata_valid_i(wdata_valid_i),
    .wdata_ready_o(wdata_ready_o),
    .wdata_o      (wdata_o),
    .wdata_last_o (wdata_last_o),
    .wdata_valid_o(wdata_valid_o),
    .wdata_ready_i(wdata_ready_i),
    .pending_o    (pending_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    wdata_t data;
    logic   last;
  } beat_t;

  typedef struct {
    int n;
    int l0;
    int l1;
    int l2;
    int mode;
    int exp_beats;
    int exp_lasts;
    int exp_gap;
  } row_t;

  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     seq = 0;
  int     push_cyc = 0;
  int     rdy_mode = 2;
  bit     tog = 1'b0;
  bit     pop_flag = 1'b0;
  waddr_t exp_addr_q[$];
  beat_t  exp_beat_q[$];
  wdata_t gen_q[$];
  int     beat_cyc_q[$];
  bit     beat_last_q[$];
  int     addr_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: 0 = always ready, 1 = toggling, 2 = never ready.
  always begin
    @(posedge clk);
    #1;
    tog = ~tog;
  end
  always @* wdata_ready_i = (rdy_mode == 1) ? tog : (rdy_mode == 0);

  // Upstream generator presents queued beats in order.
  always begin
    @(posedge clk);
    #1;
    if (pop_flag && gen_q.size() > 0) void'(gen_q.pop_front());
    pop_flag = 1'b0;
    wdata_valid_i = (gen_q.size() > 0);
    wdata_i = (gen_q.size() > 0) ? gen_q[0] : '0;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    waddr_t ea;
    beat_t  eb;
    if (rst_ni) begin
      if (waddr_valid_o && waddr_ready_i) begin
        addr_cyc_q.push_back(cyc);
        if (exp_addr_q.size() == 0) chk("waddr_unexpected", 1, 0);
        else begin
          ea = exp_addr_q.pop_front();
          chk("waddr_o", waddr_o, ea);
        end
      end
      if (wdata_valid_o && wdata_ready_i) begin
        beat_cyc_q.push_back(cyc);
        beat_last_q.push_back(wdata_last_o);
        pop_flag = 1'b1;
        if (exp_beat_q.size() == 0) chk("beat_unexpected", 1, 0);
        else begin
          eb = exp_beat_q.pop_front();
          chk("wdata_o", wdata_o, eb.data);
          chk("wdata_last_o", wdata_last_o, eb.last);
        end
      end
    end
  end

  task automatic push(input int len);
    waddr_t a;
    beat_t  e;
    seq++;
    a.id = seq[IdWidth-1:0];
    a.addr = AddrWidth'(seq * 16);
    a.burst_len = AxLenWidth'(len);
    waddr_i = a;
    waddr_valid_i = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (waddr_ready_o) begin
        push_cyc = cyc;
        exp_addr_q.push_back(a);
        for (int b = 0; b < len; b++) begin
          e.data = 32'(seq * 256 + b);
          e.last = (b == len - 1);
          gen_q.push_back(e.data);
          exp_beat_q.push_back(e);
        end
        @(posedge clk);
        #1;
        waddr_valid_i = 1'b0;
        return;
      end
    end
    chk("push_timeout", 1, 0);
    waddr_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (exp_beat_q.size() == 0 && exp_addr_q.size() == 0) return;
      @(posedge clk);
      #1;
    end
    chk("drain_timeout", exp_beat_q.size() + exp_addr_q.size(), 0);
  endtask

  task automatic clear_logs();
    beat_cyc_q.delete();
    beat_last_q.delete();
    addr_cyc_q.delete();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_waddr_valid_o"}, waddr_valid_o, 0);
    chk({tag, "_wdata_valid_o"}, wdata_valid_o, 0);
    chk({tag, "_wdata_ready_o"}, wdata_ready_o, 0);
    chk({tag, "_wdata_last_o"}, wdata_last_o, 0);
    chk({tag, "_waddr_ready_o"}, waddr_ready_o, 1);
    chk({tag, "_pending_o"}, pending_o, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t rows[5];
    int   first;
    int   lasts;

    rows[0] = '{3, 2, 0, 3, 0, 5, 2, 2};
    rows[1] = '{1, MaxWBurstLen, 0, 0, 1, MaxWBurstLen, 1, 0};
    rows[2] = '{3, 1, 1, 1, 0, 3, 3, 0};
    rows[3] = '{3, 0, 0, 4, 1, 4, 1, 0};
    rows[4] = '{2, 3, 5, 0, 1, 8, 2, 0};

    // Reset state.
    rdy_mode = 0;
    waddr_ready_i = 1'b1;
    #12;
    chk_idle("reset");
    @(posedge clk);
    #2;
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // Single len-4 burst latency.
    clear_logs();
    push(4);
    wait_drain(40);
`ifdef SIMMEM_WDATA_EARLY_EN
    first = 1;
`else
    first = 2;
`endif
    chk("t1_addr_count", addr_cyc_q.size(), 1);
    if (addr_cyc_q.size() == 1) chk("t1_addr_cycle", addr_cyc_q[0] - push_cyc, 1);
    chk("t1_beat_count", beat_cyc_q.size(), 4);
    if (beat_cyc_q.size() == 4) begin
      for (int b = 0; b < 4; b++) begin
        chk("t1_beat_cycle", beat_cyc_q[b] - push_cyc, first + b);
        chk("t1_last_pos", beat_last_q[b], (b == 3));
      end
    end

    // Fill the queue with addresses blocked.
    clear_logs();
    waddr_ready_i = 1'b0;
    rdy_mode = 0;
    for (int i = 0; i < Depth; i++) push(2);
    waddr_i = '0;
    waddr_valid_i = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("full_waddr_ready_o", waddr_ready_o, 0);
    chk("full_pending_o", pending_o, Depth);
`ifdef SIMMEM_WDATA_EARLY_EN
    chk("full_early_beats", beat_cyc_q.size(), 2 * Depth);
`else
    chk("full_wdata_ready_o", wdata_ready_o, 0);
    chk("full_no_beats", beat_cyc_q.size(), 0);
`endif
    @(posedge clk);
    #1;
    waddr_valid_i = 1'b0;
    waddr_ready_i = 1'b1;
    wait_drain(200);
    chk("full_addr_count", addr_cyc_q.size(), Depth);
    @(negedge clk);
    chk("full_drained_pending", pending_o, 0);
    @(posedge clk);
    #1;

    // Push, address issue and (address-first) data completion in one cycle.
    clear_logs();
    waddr_ready_i = 1'b0;
`ifdef SIMMEM_WDATA_EARLY_EN
    rdy_mode = 0;
    for (int i = 0; i < 3; i++) push(1);
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    chk("p3_before", pending_o, 3);
    @(posedge clk);
    #1;
`else
    rdy_mode = 2;
    for (int i = 0; i < 3; i++) push(1);
    @(negedge clk);
    chk("p3_before", pending_o, 3);
    @(posedge clk);
    #1;
    waddr_ready_i = 1'b1;
    @(posedge clk);
    #1;
    waddr_ready_i = 1'b0;
    rdy_mode = 0;
`endif
    waddr_ready_i = 1'b1;
    push(1);
    waddr_ready_i = 1'b0;
    rdy_mode = 2;
    @(negedge clk);
    chk("p3_after", pending_o, 3);
    @(posedge clk);
    #1;
    waddr_ready_i = 1'b1;
    rdy_mode = 0;
    wait_drain(100);
    chk("p3_addr_count", addr_cyc_q.size(), 4);

    // Table of burst mixes.
    for (int r = 0; r < 5; r++) begin
      clear_logs();
      rdy_mode = rows[r].mode;
      waddr_ready_i = 1'b1;
      if (rows[r].n > 0) push(rows[r].l0);
      if (rows[r].n > 1) push(rows[r].l1);
      if (rows[r].n > 2) push(rows[r].l2);
      wait_drain(200);
      lasts = 0;
      foreach (beat_last_q[k]) if (beat_last_q[k]) lasts++;
      chk("row_beats", beat_cyc_q.size(), rows[r].exp_beats);
      chk("row_lasts", lasts, rows[r].exp_lasts);
      if (rows[r].exp_gap != 0 && beat_cyc_q.size() == rows[r].exp_beats)
        chk("row_zero_len_gap", beat_cyc_q[2] - beat_cyc_q[1], rows[r].exp_gap);
    end
    rdy_mode = 0;

    // Reset in the middle of a burst.
    clear_logs();
    push(4);
    for (int i = 0; i < 30 && beat_cyc_q.size() < 2; i++) @(negedge clk);
    chk("mid_two_beats", beat_cyc_q.size(), 2);
    @(posedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_idle("midrst");
    exp_addr_q.delete();
    exp_beat_q.delete();
    gen_q.delete();
    pop_flag = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    clear_logs();
    push(2);
    wait_drain(40);
    chk("post_rst_beats", beat_cyc_q.size(), 2);
    if (beat_cyc_q.size() == 2) begin
      chk("post_rst_first_not_last", beat_last_q[0], 0);
      chk("post_rst_second_last", beat_last_q[1], 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
